// File: rtl/duty_pwm_driver.sv
// duty_pwm_driver: two-channel 64-step PWM with shared prescale/phase
// counters and double-buffered duty registers.
// Ports: sysclk (clock), Reset_N (async active-low reset), Enable (run),
//   DC_X/DC_Y (6-bit target duties), PWM_X/PWM_Y (registered waveforms),
//   Period_Start (1-cycle pulse when new duties apply),
//   Active_X/Active_Y (duties currently applied).
// Build option: define DUTY_SLEW_LIMIT_EN to rate-limit duty changes to
//   SLEW_STEP per period; otherwise each boundary loads the target.

module duty_pwm_driver #(
  parameter int unsigned PRESCALE  = 16,
  parameter int unsigned SLEW_STEP = 1
) (
  input  logic       sysclk,
  input  logic       Reset_N,
  input  logic       Enable,
  input  logic [5:0] DC_X,
  input  logic [5:0] DC_Y,
  output logic       PWM_X,
  output logic       PWM_Y,
  output logic       Period_Start,
  output logic [5:0] Active_X,
  output logic [5:0] Active_Y
);

  localparam int unsigned PW =
    (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

  if (PRESCALE < 1 || PRESCALE > 256) begin : g_bad_pre
    $error("PRESCALE out of range 1..256");
  end
  if (SLEW_STEP < 1 || SLEW_STEP > 63) begin : g_bad_slew
    $error("SLEW_STEP out of range 1..63");
  end

  logic [PW-1:0] presc_q, presc_d;
  logic [5:0]    phase_q, phase_d;
  logic          run_q, run_d;
  logic [5:0]    act_x_q, act_x_d;
  logic [5:0]    act_y_q, act_y_d;
  logic          pwm_x_q, pwm_x_d;
  logic          pwm_y_q, pwm_y_d;
  logic          ps_q, ps_d;
  logic          tick;
  logic          bound;

`ifdef DUTY_SLEW_LIMIT_EN
  localparam logic [5:0] STEP = 6'(SLEW_STEP);

  function automatic logic [5:0] next_duty(
    input logic [5:0] cur,
    input logic [5:0] tgt
  );
    logic [5:0] diff;
    next_duty = cur;
    if (tgt > cur) begin
      diff = tgt - cur;
      next_duty = (diff > STEP) ? cur + STEP : tgt;
    end else if (tgt < cur) begin
      diff = cur - tgt;
      next_duty = (diff > STEP) ? cur - STEP : tgt;
    end
  endfunction
`else
  function automatic logic [5:0] next_duty(
    input logic [5:0] cur,
    input logic [5:0] tgt
  );
    logic [5:0] unused;
    unused = cur;
    next_duty = tgt;
  endfunction
`endif

  // run_q is low until the first tick after enable; that tick is a
  // period boundary regardless of the phase value.
  always_comb begin
    presc_d = presc_q;
    phase_d = phase_q;
    run_d   = run_q;
    act_x_d = act_x_q;
    act_y_d = act_y_q;
    tick    = Enable && (presc_q == PRE_MAX);
    bound   = tick && (!run_q || phase_q == 6'd63);
    if (!Enable) begin
      presc_d = '0;
      phase_d = '0;
      run_d   = 1'b0;
    end else begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      if (bound) begin
        phase_d = '0;
        run_d   = 1'b1;
        act_x_d = next_duty(act_x_q, DC_X);
        act_y_d = next_duty(act_y_q, DC_Y);
      end else if (tick) begin
        phase_d = phase_q + 6'd1;
      end
    end
    ps_d    = bound;
    pwm_x_d = run_d && (phase_d < act_x_d);
    pwm_y_d = run_d && (phase_d < act_y_d);
  end

  always_ff @(posedge sysclk or negedge Reset_N) begin
    if (!Reset_N) begin
      presc_q <= '0;
      phase_q <= '0;
      run_q   <= 1'b0;
      act_x_q <= '0;
      act_y_q <= '0;
      pwm_x_q <= 1'b0;
      pwm_y_q <= 1'b0;
      ps_q    <= 1'b0;
    end else begin
      presc_q <= presc_d;
      phase_q <= phase_d;
      run_q   <= run_d;
      act_x_q <= act_x_d;
      act_y_q <= act_y_d;
      pwm_x_q <= pwm_x_d;
      pwm_y_q <= pwm_y_d;
      ps_q    <= ps_d;
    end
  end

  assign PWM_X        = pwm_x_q;
  assign PWM_Y        = pwm_y_q;
  assign Period_Start = ps_q;
  assign Active_X     = act_x_q;
  assign Active_Y     = act_y_q;

endmodule

// File: tb/tb_duty_pwm_driver.sv
// tb_duty_pwm_driver: bench for duty_pwm_driver, two instances
// (PRESCALE=3 slew 1, PRESCALE=1 slew 63) against an arithmetic model.

module tb_duty_pwm_driver;

  localparam int P_A = 3;
  localparam int S_A = 1;
  localparam int P_B = 1;
  localparam int S_B = 63;

  logic       sysclk  = 1'b0;
  logic       Reset_N = 1'b0;
  logic       Enable  = 1'b0;
  logic [5:0] DC_X    = '0;
  logic [5:0] DC_Y    = '0;
  logic [1:0] pwm_x, pwm_y, ps;
  logic [5:0] act_x [2];
  logic [5:0] act_y [2];

  int n_chk  = 0;
  int n_pass = 0;

  duty_pwm_driver #(.PRESCALE(P_A), .SLEW_STEP(S_A)) u_a (
    .sysclk(sysclk), .Reset_N(Reset_N), .Enable(Enable),
    .DC_X(DC_X), .DC_Y(DC_Y),
    .PWM_X(pwm_x[0]), .PWM_Y(pwm_y[0]),
    .Period_Start(ps[0]),
    .Active_X(act_x[0]), .Active_Y(act_y[0])
  );

  duty_pwm_driver #(.PRESCALE(P_B), .SLEW_STEP(S_B)) u_b (
    .sysclk(sysclk), .Reset_N(Reset_N), .Enable(Enable),
    .DC_X(DC_X), .DC_Y(DC_Y),
    .PWM_X(pwm_x[1]), .PWM_Y(pwm_y[1]),
    .Period_Start(ps[1]),
    .Active_X(act_x[1]), .Active_Y(act_y[1])
  );

  always #5 sysclk = ~sysclk;

  task automatic check(input string name, input int got,
                       input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t",
                  name, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // cyc = enabled edges seen since enable/reset (-1 when idle).
  // Boundaries fall on edges where cyc-(P-1) is a multiple of 64*P.
  int         pre [2] = '{P_A, P_B};
  int         stp [2] = '{S_A, S_B};
  int         cyc [2] = '{-1, -1};
  logic [5:0] m_ax [2] = '{6'd0, 6'd0};
  logic [5:0] m_ay [2] = '{6'd0, 6'd0};
  logic       m_px [2] = '{1'b0, 1'b0};
  logic       m_py [2] = '{1'b0, 1'b0};
  logic       m_ps [2] = '{1'b0, 1'b0};

  function automatic logic [5:0] approach(input logic [5:0] cur,
                                          input logic [5:0] tgt,
                                          input int step);
    int c;
    int t;
    c = int'(cur);
    t = int'(tgt);
`ifdef DUTY_SLEW_LIMIT_EN
    if (t > c) c = (t - c > step) ? c + step : t;
    else if (t < c) c = (c - t > step) ? c - step : t;
    return 6'(c);
`else
    if (step < 0) return 6'(c);
    return 6'(t);
`endif
  endfunction

  always @(posedge sysclk or negedge Reset_N) begin
    int pos;
    int ph;
    for (int i = 0; i < 2; i++) begin
      if (!Reset_N) begin
        cyc[i]  = -1;
        m_ax[i] = '0;
        m_ay[i] = '0;
      end else if (!Enable) begin
        cyc[i] = -1;
      end else begin
        cyc[i] = cyc[i] + 1;
      end
      m_px[i] = 1'b0;
      m_py[i] = 1'b0;
      m_ps[i] = 1'b0;
      if (Reset_N && cyc[i] >= pre[i] - 1) begin
        pos = (cyc[i] - (pre[i] - 1)) % (64 * pre[i]);
        ph  = pos / pre[i];
        if (pos == 0) begin
          m_ax[i] = approach(m_ax[i], DC_X, stp[i]);
          m_ay[i] = approach(m_ay[i], DC_Y, stp[i]);
          m_ps[i] = 1'b1;
        end
        m_px[i] = ph < int'(m_ax[i]);
        m_py[i] = ph < int'(m_ay[i]);
      end
    end
  end

  always @(negedge sysclk) begin
    for (int i = 0; i < 2; i++) begin
      check($sformatf("model pwm_x[%0d]", i), pwm_x[i], m_px[i]);
      check($sformatf("model pwm_y[%0d]", i), pwm_y[i], m_py[i]);
      check($sformatf("model ps[%0d]", i), ps[i], m_ps[i]);
      check($sformatf("model act_x[%0d]", i), act_x[i], m_ax[i]);
      check($sformatf("model act_y[%0d]", i), act_y[i], m_ay[i]);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic wait_ps(input int i, input int lim);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < lim; k++) begin
      @(negedge sysclk);
      if (ps[i]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check($sformatf("wait_ps[%0d] timeout", i), 0, 1);
  endtask

  typedef struct {
    logic [5:0] dcx;
    logic [5:0] dcy;
    int         hx;
    int         hy;
  } vec_t;

  vec_t tbl [4];

  initial begin
    int nx;
    int ny;
    int np;
    int ex;

    tbl[0] = '{dcx: 6'd16, dcy: 6'd48, hx: 16, hy: 48};
    tbl[1] = '{dcx: 6'd0,  dcy: 6'd63, hx: 0,  hy: 63};
    tbl[2] = '{dcx: 6'd63, dcy: 6'd0,  hx: 63, hy: 0};
    tbl[3] = '{dcx: 6'd1,  dcy: 6'd32, hx: 1,  hy: 32};

    // Reset held with Enable high and a nonzero duty.
    Enable = 1'b1;
    DC_X   = 6'd40;
    DC_Y   = 6'd7;
    for (int k = 0; k < 4; k++) begin
      @(negedge sysclk);
      for (int i = 0; i < 2; i++) begin
        check("rst pwm_x", pwm_x[i], 0);
        check("rst pwm_y", pwm_y[i], 0);
        check("rst ps", ps[i], 0);
        check("rst act_x", act_x[i], 0);
        check("rst act_y", act_y[i], 0);
      end
    end

    // Duty vectors on the PRESCALE=1 instance.
    foreach (tbl[v]) begin
      Enable  = 1'b0;
      Reset_N = 1'b0;
      cycles(1);
      DC_X    = tbl[v].dcx;
      DC_Y    = tbl[v].dcy;
      Reset_N = 1'b1;
      Enable  = 1'b1;
      wait_ps(1, 4);
      nx = 0;
      ny = 0;
      np = 0;
      for (int k = 0; k < 64; k++) begin
        if (k > 0) @(negedge sysclk);
        nx += int'(pwm_x[1]);
        ny += int'(pwm_y[1]);
        np += int'(ps[1]);
      end
      check($sformatf("vec%0d x highs", v), nx, tbl[v].hx);
      check($sformatf("vec%0d y highs", v), ny, tbl[v].hy);
      check($sformatf("vec%0d ps count", v), np, 1);
      check($sformatf("vec%0d act_x", v), act_x[1], tbl[v].dcx);
      cycles(1);
      check($sformatf("vec%0d ps period", v), ps[1], 1);
    end

    // Double buffer: change mid-period applies at the next boundary.
    DC_X = 6'd16;
    wait_ps(1, 70);
    check("dbuf act before", act_x[1], 16);
    nx = 0;
    for (int k = 0; k < 64; k++) begin
      if (k > 0) @(negedge sysclk);
      nx += int'(pwm_x[1]);
      if (k == 10) DC_X = 6'd48;
    end
    check("dbuf highs", nx, 16);
    check("dbuf act held", act_x[1], 16);
    cycles(1);
    check("dbuf ps", ps[1], 1);
    check("dbuf act after", act_x[1], 48);

    // Enable dropped at phase 30.
    cycles(30);
    check("drop pwm before", pwm_x[1], 1);
    Enable = 1'b0;
    cycles(1);
    check("drop pwm_x", pwm_x[1], 0);
    check("drop pwm_y", pwm_y[1], 0);
    check("drop ps", ps[1], 0);
    check("drop act kept", act_x[1], 48);
    cycles(5);
    check("idle pwm_x", pwm_x[1], 0);
    Enable = 1'b1;
    cycles(1);
    check("restart ps b", ps[1], 1);
    check("restart ps a early", ps[0], 0);
    cycles(2);
    check("restart ps a", ps[0], 1);

    // Short async reset pulse at phase 40.
    DC_X = 6'd20;
    DC_Y = 6'd50;
    wait_ps(1, 70);
    cycles(40);
    check("pre-rst pwm_y", pwm_y[1], 1);
    check("pre-rst act_x", act_x[1], 20);
    #1 Reset_N = 1'b0;
    #2;
    check("arst pwm_y", pwm_y[1], 0);
    check("arst act_x", act_x[1], 0);
    check("arst act_y", act_y[1], 0);
    check("arst act_x a", act_x[0], 0);
    Reset_N = 1'b1;
    @(negedge sysclk);
    check("arst restart ps", ps[1], 1);
    check("arst restart act", act_x[1], 20);

    // Slew ramp on the SLEW_STEP=1 instance.
    Enable  = 1'b0;
    Reset_N = 1'b0;
    cycles(1);
    DC_X    = 6'd10;
    DC_Y    = 6'd0;
    Reset_N = 1'b1;
    Enable  = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      wait_ps(0, 200);
`ifdef DUTY_SLEW_LIMIT_EN
      ex = (k < 10) ? k : 10;
`else
      ex = 10;
`endif
      check($sformatf("slew k=%0d", k), act_x[0], ex);
    end

    // Randomized run, checked by the model every cycle.
    for (int k = 0; k < 4000; k++) begin
      @(negedge sysclk);
      if ($urandom_range(15) == 0) DC_X = 6'($urandom);
      if ($urandom_range(15) == 0) DC_Y = 6'($urandom);
      if (Enable && $urandom_range(399) == 0) Enable = 1'b0;
      else if (!Enable && $urandom_range(7) == 0) Enable = 1'b1;
      if ($urandom_range(1499) == 0) begin
        #1 Reset_N = 1'b0;
        #2 Reset_N = 1'b1;
      end
    end

    cycles(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/duty_pwm_driver.md
DUTY_PWM_DRIVER -- requirements
Module: duty_pwm_driver

Interface
REQ-001 SHALL have parameter PRESCALE, default 16: sysclk cycles per PWM tick, legal range 1..256.
REQ-002 SHALL have parameter SLEW_STEP, default 1: maximum active-duty change per PWM period, legal range 1..63; used only when slew limiting is compiled in.
REQ-003 SHALL have port sysclk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset_N, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port Enable, input, 1 bit: run the PWM when high; idle when low.
REQ-006 SHALL have port DC_X, input, 6 bits: target duty for channel X (0..63); may change at any cycle.
REQ-007 SHALL have port DC_Y, input, 6 bits: target duty for channel Y (0..63); may change at any cycle.
REQ-008 SHALL have port PWM_X, output, 1 bit: registered PWM waveform for channel X.
REQ-009 SHALL have port PWM_Y, output, 1 bit: registered PWM waveform for channel Y.
REQ-010 SHALL have port Period_Start, output, 1 bit: one-sysclk pulse in the cycle in which active duties are updated.
REQ-011 SHALL have port Active_X, output, 6 bits: duty currently applied to PWM_X.
REQ-012 SHALL have port Active_Y, output, 6 bits: duty currently applied to PWM_Y.

Function
REQ-013 SHALL keep a prescale counter 0..PRESCALE-1; a tick is the cycle in which it equals PRESCALE-1, after which it returns to 0.
REQ-014 SHALL keep a 6-bit phase counter that advances by 1 on each tick and wraps from 63 to 0; one period is 64 ticks.
REQ-015 SHALL sample DC_X/DC_Y only on a period boundary: the tick that wraps phase from 63 to 0, or the first tick after Enable rises.
REQ-016 SHALL never change Active_X/Active_Y mid-period (double buffering); DC changes inside a period take effect at the next boundary.
REQ-017 SHALL pulse Period_Start high for exactly the cycle after each boundary tick, aligned with the first cycle Active_X/Active_Y show the new value.
REQ-018 SHALL drive PWM_X = (phase < Active_X), registered, for each tick (Y likewise); PWM_X is high for Active_X*PRESCALE of every 64*PRESCALE cycles.
REQ-019 SHALL hold PWM low for the whole period at duty 0, and high for 63 of 64 ticks at duty 63; no single-tick glitches at boundaries.
REQ-020 SHALL, while Enable is low, hold PWM_X, PWM_Y and Period_Start at 0, hold the prescale and phase counters at 0, and retain Active_X/Active_Y.
REQ-021 SHALL treat Enable falling mid-period as immediate: PWM outputs go low in the next cycle, and the partial period is discarded.
REQ-022 SHALL run channels X and Y from shared counters so their periods are phase-aligned.

Reset
REQ-023 SHALL on Reset_N low asynchronously clear the counters, Active_X, Active_Y, PWM_X, PWM_Y and Period_Start to 0; this applies mid-period too.
REQ-024 SHALL after Reset_N rises with Enable high, perform the first boundary sample on the first tick.

Configuration
REQ-025 SHALL use macro DUTY_SLEW_LIMIT_EN.
REQ-026 With the macro defined, each boundary SHALL move each active duty toward its sampled target by min(SLEW_STEP, |target-active|), with no overshoot or wrap.
REQ-027 Without the macro defined, each boundary SHALL load the sampled target directly; SLEW_STEP SHALL be ignored.

Verification
REQ-028 Reset: Reset_N=0 with Enable=1 and DC_X=40 -> all outputs 0 for the whole reset.
REQ-029 PRESCALE=1, DC_X=16, DC_Y=48, Enable=1 -> each 64-cycle period has PWM_X high 16 cycles and PWM_Y high 48 cycles; Period_Start occurs every 64 cycles.
REQ-030 Double buffer: DC_X changes 16->48 at phase 10 -> rest of current period uses 16; the next Period_Start shows Active_X=48.
REQ-031 Extremes: DC_X=0 -> PWM_X never high; DC_X=63 -> PWM_X high 63 of every 64 ticks; Enable dropped at phase 30 -> PWM low next cycle and counters at 0.
REQ-032 Slew (macro defined, SLEW_STEP=1): Active_X=0, DC_X=10 -> Active_X reads 1,2,...,10 at 10 successive Period_Starts, then holds; the same case without the macro -> 10 at the first boundary.
REQ-033 Async reset: Reset_N pulsed low for less than 1 sysclk at phase 40 -> outputs clear immediately; restart per REQ-024.
